// File: rtl/tinyml_isa_pkg.sv
// Shared ISA definitions for the tinyML accelerator: opcodes, sequencer states and default sizes.
package tinyml_isa_pkg;

  localparam int DEFAULT_INSTR_BYTES = 8;
  localparam int DEFAULT_INSTR_BITS  = DEFAULT_INSTR_BYTES * 8;

  // HALT and NOP share encoding 0x00: a zero opcode always ends the program.
  typedef enum logic [4:0] {
    OP_HALT   = 5'h00,
    OP_LOAD_V = 5'h01,
    OP_LOAD_M = 5'h02,
    OP_STORE  = 5'h03,
    OP_GEMV   = 5'h04,
    OP_RELU   = 5'h05
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_EXEC,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/instr_byte_assembler.sv
// Collects MEM_LATENCY-delayed read bytes MSB-first into one instruction and flags the last byte.
module instr_byte_assembler #(
  parameter int INSTR_BYTES = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_strobe,
  input  logic [7:0]               i_rdata,
  output logic                     o_last,
  output logic [INSTR_BYTES*8-1:0] o_instr_next
);
  localparam int INSTR_BITS = INSTR_BYTES * 8;
  localparam int CNT_W      = $clog2(INSTR_BYTES + 1);

  logic [MEM_LATENCY-1:0] r_vld;
  logic [CNT_W-1:0]       r_cnt;
  logic [INSTR_BITS-1:0]  r_shift;
  logic                   w_cap;

  // Oldest strobe in the delay line marks the cycle its byte is on i_rdata.
  assign w_cap        = r_vld[MEM_LATENCY-1];
  assign o_last       = w_cap && (r_cnt == CNT_W'(INSTR_BYTES - 1));
  assign o_instr_next = (r_shift << 8) | INSTR_BITS'(i_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      r_vld <= (r_vld << 1) | MEM_LATENCY'(i_strobe);
      if (w_cap) r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_shift <= o_instr_next;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Byte-serial instruction fetch and valid/ready dispatch unit for the tinyML accelerator.
// Build option INSTR_PREFETCH_EN: fetch the next instruction into a one-entry buffer during WAIT_EXEC.
module instr_sequencer
  import tinyml_isa_pkg::*;
#(
  parameter int INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int ADDR_WIDTH   = 24,
  parameter int BASE_ADDR    = 0,
  parameter int MAX_INSTR    = 256,
  parameter int MEM_LATENCY  = 1,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_rd_en,
  input  logic [7:0]                     mem_rdata,
  output logic [INSTR_BYTES*8-1:0]       instr,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  input  logic                           exec_done,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [$clog2(MAX_INSTR+1)-1:0] instr_count,
  output logic                           busy,
  output logic                           done,
  output logic                           err_overrun
);
  localparam int INSTR_BITS = INSTR_BYTES * 8;
  localparam int CNT_W      = $clog2(MAX_INSTR + 1);
  localparam int RD_W       = $clog2(INSTR_BYTES + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

  seq_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_rd_en;
  logic [RD_W-1:0]       r_rd_cnt;
  logic [INSTR_BITS-1:0] r_instr;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_count;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovr;

  logic                  w_start_ok;
  logic                  w_a_strobe;
  logic                  w_a_last;
  logic [INSTR_BITS-1:0] w_a_next;
  logic                  w_exit_now;
  logic [INSTR_BITS-1:0] w_exit_instr;
  logic                  w_exit_halt;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);

  instr_byte_assembler #(
    .INSTR_BYTES (INSTR_BYTES),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_asm_a (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_strobe     (w_a_strobe),
    .i_rdata      (mem_rdata),
    .o_last       (w_a_last),
    .o_instr_next (w_a_next)
  );

`ifdef INSTR_PREFETCH_EN
  logic                  r_rd_to_b;
  logic                  r_src_b;
  logic                  r_buf_full;
  logic [INSTR_BITS-1:0] r_buf;
  logic                  w_b_last;
  logic [INSTR_BITS-1:0] w_b_next;
  logic                  w_buf_ready;

  assign w_a_strobe = r_rd_en && !r_rd_to_b;

  instr_byte_assembler #(
    .INSTR_BYTES (INSTR_BYTES),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_asm_b (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_strobe     (r_rd_en && r_rd_to_b),
    .i_rdata      (mem_rdata),
    .o_last       (w_b_last),
    .o_instr_next (w_b_next)
  );

  // A byte landing on the same cycle as exec_done counts as a complete buffer.
  assign w_buf_ready = r_buf_full || w_b_last;

  always_comb begin
    w_exit_now   = 1'b0;
    w_exit_instr = w_a_next;
    if (r_state == S_FETCH) begin
      w_exit_now   = r_src_b ? w_b_last : w_a_last;
      w_exit_instr = r_src_b ? w_b_next : w_a_next;
    end else if (r_state == S_WAIT_EXEC && exec_done) begin
      w_exit_now   = w_buf_ready;
      w_exit_instr = r_buf_full ? r_buf : w_b_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_b_last) r_buf <= w_b_next;
  end
`else
  assign w_a_strobe   = r_rd_en;
  assign w_exit_now   = (r_state == S_FETCH) && w_a_last;
  assign w_exit_instr = w_a_next;
`endif

  assign w_exit_halt = (w_exit_instr[INSTR_BITS-1 -: OPCODE_WIDTH] == OPCODE_WIDTH'(OP_HALT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= BASE;
      r_mem_addr <= '0;
      r_rd_en    <= 1'b0;
      r_rd_cnt   <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
`ifdef INSTR_PREFETCH_EN
      r_rd_to_b  <= 1'b0;
      r_src_b    <= 1'b0;
      r_buf_full <= 1'b0;
`endif
    end else begin
      // Read engine: once started it strobes INSTR_BYTES consecutive addresses.
      if (r_rd_en) begin
        if (r_rd_cnt == RD_W'(INSTR_BYTES)) begin
          r_rd_en <= 1'b0;
        end else begin
          r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
          r_rd_cnt   <= r_rd_cnt + RD_W'(1);
        end
      end

      if (w_exit_now) begin
`ifdef INSTR_PREFETCH_EN
        r_src_b <= 1'b0;
`endif
        if (w_exit_halt) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else if (r_count == CNT_W'(MAX_INSTR)) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_ovr   <= 1'b1;
        end else begin
          r_state <= S_ISSUE;
          r_valid <= 1'b1;
          r_instr <= w_exit_instr;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_pc       <= BASE;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_busy     <= 1'b1;
            r_rd_en    <= 1'b1;
            r_mem_addr <= BASE;
            r_rd_cnt   <= RD_W'(1);
`ifdef INSTR_PREFETCH_EN
            r_rd_to_b  <= 1'b0;
            r_src_b    <= 1'b0;
            r_buf_full <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT_EXEC;
            if (r_count != CNT_W'(MAX_INSTR)) r_count <= r_count + CNT_W'(1);
`ifdef INSTR_PREFETCH_EN
            r_rd_en    <= 1'b1;
            r_mem_addr <= r_pc + STEP;
            r_rd_cnt   <= RD_W'(1);
            r_rd_to_b  <= 1'b1;
            r_buf_full <= 1'b0;
`endif
          end
        end
        S_WAIT_EXEC: begin
`ifdef INSTR_PREFETCH_EN
          if (w_b_last) r_buf_full <= 1'b1;
          if (exec_done) begin
            r_pc       <= r_pc + STEP;
            r_buf_full <= 1'b0;
            if (!w_buf_ready) begin
              r_state <= S_FETCH;
              r_src_b <= 1'b1;
            end
          end
`else
          if (exec_done) begin
            r_pc       <= r_pc + STEP;
            r_state    <= S_FETCH;
            r_rd_en    <= 1'b1;
            r_mem_addr <= r_pc + STEP;
            r_rd_cnt   <= RD_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_rd_en   = r_rd_en;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign instr_count = r_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_overrun = r_ovr;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: MEM_LATENCY=2, MAX_INSTR=4, directed programs.
module tb_instr_sequencer;
  localparam int AW   = 24;
  localparam int LAT  = 2;
  localparam int MAXI = 4;
  localparam int NB   = 8;
  localparam int START_LAT = NB + LAT + 1;
`ifdef INSTR_PREFETCH_EN
  localparam int EXEC_LAT = 1;
`else
  localparam int EXEC_LAT = NB + LAT + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          instr_ready = 1'b1;
  logic          exec_done = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata;
  logic [63:0]   instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [2:0]    instr_count;
  logic          busy;
  logic          done;
  logic          err_overrun;

  instr_sequencer #(
    .INSTR_BYTES  (NB),
    .ADDR_WIDTH   (AW),
    .BASE_ADDR    (0),
    .MAX_INSTR    (MAXI),
    .MEM_LATENCY  (LAT),
    .OPCODE_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .exec_done   (exec_done),
    .pc          (pc),
    .instr_count (instr_count),
    .busy        (busy),
    .done        (done),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // Program memory with a two-cycle read pipeline.
  logic [7:0]    mem [0:255];
  logic          pv1 = 1'b0, pv2 = 1'b0;
  logic [AW-1:0] pa1 = '0, pa2 = '0;
  always @(posedge clk) begin
    pv1 <= mem_rd_en;
    pa1 <= mem_addr;
    pv2 <= pv1;
    pa2 <= pa1;
  end
  assign mem_rdata = pv2 ? mem[pa2[7:0]] : 8'hEE;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] ins;
    logic [4:0]  op;
  } exp_t;
  exp_t sb[$];
  int   exec_delay = 5;

  // Monitor/responder: pops the scoreboard on every handshake, then pulses exec_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got dispatch of %0h want none", instr);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", instr, e.ins);
          chk("sb_opcode", 64'(instr[63 -: 5]), 64'(e.op));
        end
        repeat (exec_delay) @(posedge clk);
        #1 exec_done = 1'b1;
        @(posedge clk);
        #1 exec_done = 1'b0;
      end
    end
  end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic lat_en = 1'b0;
  logic prev_v = 1'b0;
  int   t_ev = 0;
  int   exp_lat = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (start) begin t_ev = cyc; exp_lat = START_LAT; end
      if (exec_done) begin t_ev = cyc; exp_lat = EXEC_LAT; end
      if (lat_en && instr_valid && !prev_v) chk("valid_latency", 64'(cyc - t_ev), 64'(exp_lat));
      prev_v = instr_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input int a, input logic [63:0] w);
    for (int i = 0; i < NB; i++) mem[a + i] = w[63 - 8 * i -: 8];
  endtask

  task automatic push(input logic [63:0] w, input logic [4:0] op);
    exp_t e;
    e.ins = w;
    e.op  = op;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles want 1", nm, done, n);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 64'(instr_valid), 64'd0);
    chk({nm, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({nm, "_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_instr"}, instr, 64'd0);
    chk({nm, "_pc"}, 64'(pc), 64'd0);
    chk({nm, "_count"}, 64'(instr_count), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_ovr"}, 64'(err_overrun), 64'd0);
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b0;

    // Byte order plus GEMV, RELU, HALT program
    load(0,  64'h2000_0000_0000_0001);
    load(8,  64'h2800_0000_0000_0007);
    load(16, 64'h0);
    exec_delay = 5;
    push(64'h2000_0000_0000_0001, 5'h04);
    push(64'h2800_0000_0000_0007, 5'h05);
    do_start();
    chk("prog_busy", 64'(busy), 64'd1);
    wait_done("prog");
    chk("prog_pc", 64'(pc), 64'h10);
    chk("prog_count", 64'(instr_count), 64'd2);
    chk("prog_ovr", 64'(err_overrun), 64'd0);
    chk("prog_busy_end", 64'(busy), 64'd0);
    chk("prog_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: ready low for 10 cycles in ISSUE
    load(0, 64'h0811_2233_4455_6677);
    load(8, 64'h0);
    instr_ready = 1'b0;
    push(64'h0811_2233_4455_6677, 5'h01);
    do_start();
    n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(instr_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 64'(instr_valid), 64'd1);
      chk("bp_instr", instr, 64'h0811_2233_4455_6677);
      chk("bp_rd_en", 64'(mem_rd_en), 64'd0);
    end
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_drop", 64'(instr_valid), 64'd0);
    chk("bp_count", 64'(instr_count), 64'd1);
    wait_done("bp");
    chk("bp_pc", 64'(pc), 64'h8);
    chk("bp_count_end", 64'(instr_count), 64'd1);

    // Overrun: five non-HALT instructions, MAX_INSTR=4
    load(0,  64'h0801_0101_0101_0101);
    load(8,  64'h1002_0202_0202_0202);
    load(16, 64'h1803_0303_0303_0303);
    load(24, 64'h2004_0404_0404_0404);
    load(32, 64'h2805_0505_0505_0505);
    exec_delay = 3;
    push(64'h0801_0101_0101_0101, 5'h01);
    push(64'h1002_0202_0202_0202, 5'h02);
    push(64'h1803_0303_0303_0303, 5'h03);
    push(64'h2004_0404_0404_0404, 5'h04);
    do_start();
    wait_done("ovr");
    chk("ovr_flag", 64'(err_overrun), 64'd1);
    chk("ovr_pc", 64'(pc), 64'h20);
    chk("ovr_count", 64'(instr_count), 64'd4);
    chk("ovr_sb_empty", 64'(sb.size()), 64'd0);

    // Reset on the third read strobe, then restart
    load(0,  64'h2000_0000_0000_0001);
    load(8,  64'h2800_0000_0000_0007);
    load(16, 64'h0);
    do_start();
    n = 0;
    k = 0;
    while (k < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (mem_rd_en) k++;
    end
    chk("rst_third_strobe", 64'(k), 64'd3);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    tick();
    tick();
    rst = 1'b0;
    exec_delay = 5;
    push(64'h2000_0000_0000_0001, 5'h04);
    push(64'h2800_0000_0000_0007, 5'h05);
    do_start();
    n = 0;
    while (!mem_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_restart_addr", 64'(mem_addr), 64'h0);
    wait_done("rst");
    chk("rst_pc", 64'(pc), 64'h10);
    chk("rst_count", 64'(instr_count), 64'd2);
    chk("rst_sb_empty", 64'(sb.size()), 64'd0);

    // Fetch latency with slow execution
    load(0,  64'h0801_0101_0101_0101);
    load(8,  64'h1002_0202_0202_0202);
    load(16, 64'h1803_0303_0303_0303);
    load(24, 64'h0);
    exec_delay = 20;
    push(64'h0801_0101_0101_0101, 5'h01);
    push(64'h1002_0202_0202_0202, 5'h02);
    push(64'h1803_0303_0303_0303, 5'h03);
    lat_en = 1'b1;
    do_start();
    wait_done("lat");
    lat_en = 1'b0;
    chk("lat_pc", 64'(pc), 64'h18);
    chk("lat_count", 64'(instr_count), 64'd3);
    chk("lat_ovr", 64'(err_overrun), 64'd0);
    chk("lat_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
